// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared state encoding and counter width helper for the
// sequential shift-add multiplier.
// Optional build macro used by this block: SEQ_MUL_EARLY_EXIT_EN.
package seq_mul_pkg;

    // S_DONE is the only state that asserts Load.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Step counter width: ceil(log2 n), never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if: operand / product bus of the sequential multiplier.
//
// Handshake: Start is a one-cycle valid strobe carrying A and B. The
// multiplier is ready exactly when Busy is low; an edge with Start=1,
// Busy=0 and Clear=1 accepts the operands, any other Start is dropped.
// Load is a one-cycle valid pulse for P with no back-pressure: the
// consumer must capture P on the edge that ends the Load cycle.
interface seq_mul_if #(parameter int N = 8);
    logic             Start;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic             Busy;
    logic             Load;
    logic [2*N-1:0]   P;

    modport master (output Start, A, B, input Busy, Load, P);
    modport slave  (input Start, A, B, output Busy, Load, P);
endinterface

// File: rtl/seq_mul_dp.sv
// seq_mul_dp: multiplicand/multiplier shifters and 2N-bit accumulator.
// SEQ_MUL_EARLY_EXIT_EN adds the post-shift MP==0 detector; without it
// mp_done is tied low and the comparator does not exist.
module seq_mul_dp #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           clear,
    input  logic           init,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] acc_next,
    output logic           mp_done
);

    logic [2*N-1:0] mc_q;
    logic [2*N-1:0] acc_q;
    logic [N-1:0]   mp_q;

    // Post-step accumulator: add the shifted multiplicand when the current multiplier bit is set.
    always_comb acc_next = mp_q[0] ? (acc_q + mc_q) : acc_q;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    // After this step's shift no set multiplier bits remain.
    assign mp_done = (mp_q[N-1:1] == '0);
`else
    assign mp_done = 1'b0;
`endif

    // Load operands on init, shift and accumulate on each step, zero on Clear.
    always_ff @(posedge clk) begin
        if (!clear) begin
            mc_q  <= '0;
            mp_q  <= '0;
            acc_q <= '0;
        end else if (init) begin
            mc_q  <= {{N{1'b0}}, a};
            mp_q  <= b;
            acc_q <= '0;
        end else if (step) begin
            acc_q <= acc_next;
            mc_q  <= mc_q << 1;
            mp_q  <= mp_q >> 1;
        end
    end

endmodule

// File: rtl/seq_mul.sv
// seq_mul: sequential shift-add unsigned multiplier, one multiplier bit
// per clock. Holds the IDLE/RUN/DONE controller, step counter and the
// product register; datapath lives in seq_mul_dp.
// Optional build macro: SEQ_MUL_EARLY_EXIT_EN (leave RUN once the
// remaining multiplier bits are all zero).
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic      CLOCK,
    input  logic      Clear,
    seq_mul_if.slave  bus,
    output state_t    dbg_state
);

    localparam int CW = cnt_width(N);

    state_t          state_q;
    state_t          next_state;
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  p_q;
    logic [2*N-1:0]  acc_next;
    logic            mp_done;
    logic            init;
    logic            step;
    logic            last;

    seq_mul_dp #(.N(N)) u_dp (
        .clk      (CLOCK),
        .clear    (Clear),
        .init     (init),
        .step     (step),
        .a        (bus.A),
        .b        (bus.B),
        .acc_next (acc_next),
        .mp_done  (mp_done)
    );

    // Next-state and datapath enables; Start only matters in IDLE.
    always_comb begin
        next_state = state_q;
        init       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    init       = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                last = (cnt_q == CW'(N - 1)) || mp_done;
                if (last) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State, step counter and product register; Clear discards any product in flight.
    always_ff @(posedge CLOCK) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= next_state;
            if (init)
                cnt_q <= '0;
            else if (step)
                cnt_q <= cnt_q + CW'(1);
            if (last)
                p_q <= acc_next;
        end
    end

    assign bus.Busy  = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.Load  = (state_q == S_DONE);
    assign bus.P     = p_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: self-checking bench for seq_mul (N=8 main instance, N=16
// secondary instance). Latency expectations follow SEQ_MUL_EARLY_EXIT_EN.
module tb_seq_mul;
    import seq_mul_pkg::*;

    localparam int N  = 8;
    localparam int N2 = 16;

    logic CLOCK = 1'b0;
    logic Clear;

    // clock / reset block
    always #5 CLOCK = ~CLOCK;

    seq_mul_if #(.N(N))  bus();
    seq_mul_if #(.N(N2)) bus16();
    state_t dbg;
    state_t dbg16;

    seq_mul #(.N(N)) dut (
        .CLOCK     (CLOCK),
        .Clear     (Clear),
        .bus       (bus),
        .dbg_state (dbg)
    );

    seq_mul #(.N(N2)) dut16 (
        .CLOCK     (CLOCK),
        .Clear     (Clear),
        .bus       (bus16),
        .dbg_state (dbg16)
    );

    // downstream n_REG #(16) capturing on the edge that ends Load
    logic [2*N-1:0] nreg;
    always @(posedge CLOCK) if (bus.Load) nreg <= bus.P;

    int total = 0;
    int bad   = 0;
    logic [2*N-1:0] exp_q[$];

    function automatic int exp_lat(input logic [N-1:0] b);
        int l;
        l = N;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        l = 1;
        for (int i = 0; i < N; i++) if (b[i]) l = i + 1;
`endif
        return l;
    endfunction

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] ea;
        logic [2*N-1:0] eb;
        ea = {{N{1'b0}}, a};
        eb = {{N{1'b0}}, b};
        return ea * eb;
    endfunction

    // driver: one-cycle Start, then scramble operands; pushes expected product
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.Start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        exp_q.push_back(prod(a, b));
        @(posedge CLOCK); #1;
        bus.Start = 1'b0;
        bus.A     = N'($urandom);
        bus.B     = N'($urandom);
    endtask

    // bounded wait for Load on the N=8 instance
    task automatic wait_load(input int limit, output int cycles, output bit got);
        cycles = 0;
        got    = 1'b0;
        while (cycles < limit && !got) begin
            @(posedge CLOCK); #1;
            cycles++;
            if (bus.Load === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        Clear = 1'b0;
        bus.Start = 1'b1;
        bus.A = 8'd5;
        bus.B = 8'd7;
        repeat (2) @(posedge CLOCK);
        #1;
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        total++; if (bus.Load !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", bus.Load); end
        total++; if (bus.P !== 16'h0) begin bad++; $display("FAIL reset_p got=%h exp=0000", bus.P); end
        total++; if (dbg !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg); end
        bus.Start = 1'b0;
        Clear = 1'b1;
        @(posedge CLOCK); #1;
    endtask

    task automatic test_basic();
        logic [N-1:0] a_tab[8];
        logic [N-1:0] b_tab[8];
        logic [2*N-1:0] e;
        int cyc;
        bit got;
        a_tab = '{8'd13, 8'hFF, 8'd0, 8'd200, 8'd200, 8'd200, 8'd0, 8'd0};
        b_tab = '{8'd11, 8'hFF, 8'hFF, 8'd0, 8'd1, 8'h80, 8'd0, 8'd0};
        for (int i = 6; i < 8; i++) begin
            a_tab[i] = N'($urandom_range(0, 255));
            b_tab[i] = N'($urandom_range(0, 255));
        end
        for (int i = 0; i < 8; i++) begin
            start_op(a_tab[i], b_tab[i]);
            total++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL busy_after_start[%0d] got=%b exp=1", i, bus.Busy); end
            wait_load(40, cyc, got);
            total++; if (!got || cyc != exp_lat(b_tab[i])) begin
                bad++; $display("FAIL latency[%0d] got=%0d seen=%0b exp=%0d", i, cyc, got, exp_lat(b_tab[i]));
            end
            e = exp_q.pop_front();
            total++; if (bus.P !== e) begin bad++; $display("FAIL product[%0d] got=%h exp=%h", i, bus.P, e); end
            @(posedge CLOCK); #1;
            total++; if (bus.Load !== 1'b0 || bus.Busy !== 1'b0) begin
                bad++; $display("FAIL load_width[%0d] load=%b busy=%b exp=0/0", i, bus.Load, bus.Busy);
            end
            total++; if (nreg !== e) begin bad++; $display("FAIL nreg_capture[%0d] got=%h exp=%h", i, nreg, e); end
        end
        // product holds while idle
        repeat (3) @(posedge CLOCK);
        #1;
        e = prod(a_tab[7], b_tab[7]);
        total++; if (bus.P !== e) begin bad++; $display("FAIL p_hold got=%h exp=%h", bus.P, e); end
    endtask

    // Start held for 20 cycles with fresh operands every cycle; cycle model
    // of the protocol decides which operands are accepted.
    task automatic test_back_to_back();
        int mstate;
        int rem;
        int loads;
        logic [2*N-1:0] e;
        mstate = 0;
        rem = 0;
        loads = 0;
        for (int c = 0; c < 60; c++) begin
            if (c < 20) begin
                bus.Start = 1'b1;
                bus.A = N'($urandom);
                bus.B = N'($urandom);
            end else begin
                bus.Start = 1'b0;
            end
            case (mstate)
                0: if (bus.Start) begin
                    exp_q.push_back(prod(bus.A, bus.B));
                    rem = exp_lat(bus.B);
                    mstate = 1;
                end
                1: begin
                    rem--;
                    if (rem == 0) mstate = 2;
                end
                default: mstate = 0;
            endcase
            @(posedge CLOCK); #1;
            total++; if (bus.Load !== (mstate == 2)) begin
                bad++; $display("FAIL b2b_load[c%0d] got=%b exp=%b", c, bus.Load, (mstate == 2));
            end
            total++; if (bus.Busy !== (mstate != 0)) begin
                bad++; $display("FAIL b2b_busy[c%0d] got=%b exp=%b", c, bus.Busy, (mstate != 0));
            end
            if (mstate == 2) begin
                loads++;
                e = exp_q.pop_front();
                total++; if (bus.P !== e) begin bad++; $display("FAIL b2b_product[%0d] got=%h exp=%h", loads, bus.P, e); end
            end
        end
    endtask

    task automatic test_clear_abort();
        logic [2*N-1:0] e;
        int cyc;
        bit got;
        int stray;
        start_op(8'd77, 8'd201);
        repeat (3) @(posedge CLOCK);
        #1;
        Clear = 1'b0;
        @(posedge CLOCK); #1;
        Clear = 1'b1;
        void'(exp_q.pop_front());
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.Busy); end
        total++; if (bus.Load !== 1'b0) begin bad++; $display("FAIL abort_load got=%b exp=0", bus.Load); end
        total++; if (bus.P !== 16'h0) begin bad++; $display("FAIL abort_p got=%h exp=0000", bus.P); end
        total++; if (dbg !== S_IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=0", dbg); end
        stray = 0;
        for (int c = 0; c < N + 4; c++) begin
            @(posedge CLOCK); #1;
            if (bus.Load === 1'b1) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL abort_no_load got=%0d pulses exp=0", stray); end
        // Clear and Start on the same edge: reset wins
        Clear = 1'b0;
        bus.Start = 1'b1;
        bus.A = 8'd9;
        bus.B = 8'd9;
        @(posedge CLOCK); #1;
        Clear = 1'b1;
        bus.Start = 1'b0;
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL clear_start_busy got=%b exp=0", bus.Busy); end
        @(posedge CLOCK); #1;
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL clear_start_idle got=%b exp=0", bus.Busy); end
        // next operation computes correctly
        start_op(8'd19, 8'd23);
        wait_load(40, cyc, got);
        total++; if (!got || cyc != exp_lat(8'd23)) begin
            bad++; $display("FAIL restart_latency got=%0d seen=%0b exp=%0d", cyc, got, exp_lat(8'd23));
        end
        e = exp_q.pop_front();
        total++; if (bus.P !== e) begin bad++; $display("FAIL restart_product got=%h exp=%h", bus.P, e); end
        @(posedge CLOCK); #1;
    endtask

    task automatic test_wide();
        int cyc;
        int lat;
        bit got;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        lat = 2;
`else
        lat = N2;
`endif
        bus16.Start = 1'b1;
        bus16.A = 16'hFFFF;
        bus16.B = 16'h0002;
        @(posedge CLOCK); #1;
        bus16.Start = 1'b0;
        bus16.A = 16'h1234;
        bus16.B = 16'h5678;
        cyc = 0;
        got = 1'b0;
        while (cyc < 60 && !got) begin
            @(posedge CLOCK); #1;
            cyc++;
            if (bus16.Load === 1'b1) got = 1'b1;
        end
        total++; if (!got || cyc != lat) begin bad++; $display("FAIL wide_latency got=%0d seen=%0b exp=%0d", cyc, got, lat); end
        total++; if (bus16.P !== 32'h0001FFFE) begin bad++; $display("FAIL wide_product got=%h exp=0001fffe", bus16.P); end
        @(posedge CLOCK); #1;
        total++; if (bus16.Busy !== 1'b0 || bus16.Load !== 1'b0) begin
            bad++; $display("FAIL wide_end busy=%b load=%b exp=0/0", bus16.Busy, bus16.Load);
        end
    endtask

    initial begin
        Clear = 1'b0;
        bus.Start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus16.Start = 1'b0;
        bus16.A = '0;
        bus16.B = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_clear_abort();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
